// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with fill count, programmable almost-full/almost-empty, flush and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through read data; otherwise rdata is registered.
module sync_fifo_ctl #(
  parameter int unsigned DSIZE      = 8,
  parameter int unsigned ASIZE      = 4,
  parameter int unsigned AFULL_LVL  = 12,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  input  logic             flush,
  input  logic             err_clr,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned CW    = ASIZE + 1;

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [ASIZE-1:0] r_waddr;
  logic [ASIZE-1:0] r_raddr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_wr_err;
  logic             w_rd_err;

  // Status decodes straight from the registered occupancy.
  assign wfull        = (r_count == CW'(DEPTH));
  assign rempty       = (r_count == CW'(0));
  assign almost_full  = (r_count >= CW'(AFULL_LVL));
  assign almost_empty = (r_count <= CW'(AEMPTY_LVL));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // A flush cycle swallows both requests without raising errors.
  assign w_wr_ok  = winc & ~wfull  & ~flush;
  assign w_rd_ok  = rinc & ~rempty & ~flush;
  assign w_wr_err = winc &  wfull  & ~flush;
  assign w_rd_err = rinc &  rempty & ~flush;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) begin
        r_waddr <= r_waddr + ASIZE'(1);
      end
      if (w_rd_ok) begin
        r_raddr <= r_raddr + ASIZE'(1);
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky errors: a fresh error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_err) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_rd_err) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = r_mem[r_raddr];
`else
  logic [DSIZE-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_rd_ok) begin
      r_rdata <= r_mem[r_raddr];
    end
  end

  assign rdata = r_rdata;
`endif

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl with a queue-based reference model checked every cycle.
module tb_sync_fifo_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       flush;
  logic       err_clr;
  logic       wfull;
  logic       rempty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] m_rdata;
  logic       m_ovf;
  logic       m_udf;
  bit         m_valid = 1'b0;

  sync_fifo_ctl #(.DSIZE(8), .ASIZE(4), .AFULL_LVL(12), .AEMPTY_LVL(2)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata),
    .flush(flush), .err_clr(err_clr), .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: occupancy is the queue length; flags follow from the stated thresholds.
  task automatic model_edge();
    bit full, empty, wr, rd;
    if (!rst_n) begin
      q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_rdata = 8'h00;
      m_valid = 1'b1;
    end else begin
      if (winc && q.size() == 16 && !flush) m_ovf = 1'b1;
      else if (err_clr) m_ovf = 1'b0;
      if (rinc && q.size() == 0 && !flush) m_udf = 1'b1;
      else if (err_clr) m_udf = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        full  = (q.size() == 16);
        empty = (q.size() == 0);
        wr    = winc && !full;
        rd    = rinc && !empty;
        if (rd) m_rdata = q.pop_front();
        if (wr) q.push_back(wdata);
      end
    end
  endtask

  task automatic compare_all();
    if (!m_valid) return;
    chk("count", 32'(count), 32'(q.size()));
    chk("wfull", 32'(wfull), 32'(q.size() == 16));
    chk("rempty", 32'(rempty), 32'(q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 12));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    if (q.size() != 0) chk("rdata_fwft", 32'(rdata), 32'(q[0]));
`else
    chk("rdata", 32'(rdata), 32'(m_rdata));
`endif
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic f, input logic e, input logic rn);
    winc = w; wdata = d; rinc = r; flush = f; err_clr = e; rst_n = rn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr(input logic [7:0] d); cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic rd();                    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1); endtask

  // Pops one word and pins it to a literal expectation in either read mode.
  task automatic rd_expect(input string name, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk(name, 32'(rdata), 32'(exp));
    rd();
`else
    rd();
    chk(name, 32'(rdata), 32'(exp));
`endif
  endtask

  initial begin
    winc = 0; wdata = 0; rinc = 0; flush = 0; err_clr = 0; rst_n = 0;
    @(negedge clk);

    // Reset
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_wfull", 32'(wfull), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_errs", 32'({overflow, underflow}), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_rdata", 32'(rdata), 32'h00);
`endif

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 11));
    end
    chk("full_count", 32'(count), 32'd16);
    chk("full_wfull", 32'(wfull), 32'd1);
    wr(8'hAA);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd_expect("drain_data", 8'(i));
      chk("drain_aempty", 32'(almost_empty), 32'(i >= 13));
    end
    chk("drain_rempty", 32'(rempty), 32'd1);

    // Pointer wrap
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 10; j++) wr(8'(8'h40 + 16 * k + j));
      for (int j = 0; j < 10; j++) rd_expect("wrap_data", 8'(8'h40 + 16 * k + j));
    end
    chk("wrap_count", 32'(count), 32'd0);
    rd();
    chk("udf_set", 32'(underflow), 32'd1);
    cyc(0, 8'h00, 0, 0, 1, 1);
    chk("errclr", 32'({overflow, underflow}), 32'd0);

    // Error set beats simultaneous clear
    cyc(0, 8'h00, 1, 0, 1, 1);
    chk("udf_beats_clr", 32'(underflow), 32'd1);
    cyc(0, 8'h00, 0, 0, 1, 1);

    // Simultaneous read/write
    for (int i = 0; i < 5; i++) wr(8'(8'h20 + i));
    for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("simul_data", 32'(rdata), 32'(i < 5 ? 8'h20 + i : 8'h30 + i - 5));
      cyc(1, 8'(8'h30 + i), 1, 0, 0, 1);
`else
      cyc(1, 8'(8'h30 + i), 1, 0, 0, 1);
      chk("simul_data", 32'(rdata), 32'(i < 5 ? 8'h20 + i : 8'h30 + i - 5));
`endif
      chk("simul_count", 32'(count), 32'd5);
    end
    for (int i = 0; i < 11; i++) wr(8'(8'h60 + i));
    cyc(1, 8'hEE, 1, 0, 0, 1);
    chk("full_rw_count", 32'(count), 32'd15);
    chk("full_rw_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 15; i++) rd();

    // Flush
    for (int i = 0; i < 7; i++) wr(8'(8'h80 + i));
    cyc(1, 8'hBB, 1, 1, 0, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_rempty", 32'(rempty), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd1);
    chk("flush_udf", 32'(underflow), 32'd0);
    wr(8'h5A);
    rd_expect("post_flush", 8'h5A);

    // Read latency
    wr(8'h3C);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_data", 32'(rdata), 32'h3C);
    chk("fwft_rempty", 32'(rempty), 32'd0);
    rd();
`else
    chk("std_hold", 32'(rdata), 32'h5A);
    rd();
    chk("std_latency", 32'(rdata), 32'h3C);
`endif

    // Reset mid-traffic, and reset outranks flush
    for (int i = 0; i < 3; i++) wr(8'(8'h90 + i));
    cyc(0, 8'h00, 0, 1, 0, 0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_errs", 32'({overflow, underflow}), 32'd0);
    wr(8'h77);
    rd_expect("post_reset", 8'h77);
    cyc(0, 8'h00, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
